// File: rtl/median_seq_ctrl.sv
// Sequencer for the 1-D median filter: captures button-entered samples into the
// sample RAM, then per step fetches an edge-replicated 3-sample window and stores its median.
module median_seq_ctrl #(
    parameter int DW    = 8,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic          load_pulse,
    input  logic          step_pulse,
    input  logic [DW-1:0] sample_in,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] win0,
    output logic [DW-1:0] win1,
    output logic [DW-1:0] win2,
    output logic          win_valid,
    input  logic [DW-1:0] med_in,
    output logic          res_we,
    output logic [AW-1:0] res_addr,
    output logic [DW-1:0] res_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] disp_idx
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CAPTURE = 4'd1,
        S_HOLD    = 4'd2,
        S_F0      = 4'd3,
        S_F1      = 4'd4,
        S_F2      = 4'd5,
        S_F3      = 4'd6,
        S_EVAL    = 4'd7,
        S_WRITE   = 4'd8,
        S_DONE    = 4'd9
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_W   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] idx_r;
    logic          cap_accept_s;
    logic          abort_s;
    logic          last_s;
    logic [AW:0]   cap_count_s;
    logic [AW:0]   idx_ext_s;
    logic [AW-1:0] left_s;
    logic [AW-1:0] right_s;

    // Capture acceptance, load-abort detection and clamped window addresses
    always_comb begin
        idx_ext_s    = {1'b0, idx_r};
        cap_accept_s = (state_r == S_CAPTURE) && load_pulse && (count < DEPTH_C);
        abort_s      = load && (state_r != S_CAPTURE);
        last_s       = ((idx_ext_s + ONE_W) == count);
        if (cap_accept_s) begin
            cap_count_s = count + ONE_W;
        end else begin
            cap_count_s = count;
        end
        if (idx_r == {AW{1'b0}}) begin
            left_s = idx_r;
        end else begin
            left_s = idx_r - ONE_A;
        end
        if (last_s) begin
            right_s = idx_r;
        end else begin
            right_s = idx_r + ONE_A;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a raised load outranks every state except CAPTURE itself
    always_comb begin
        state_s = state_r;
        if (abort_s) begin
            state_s = S_CAPTURE;
        end else begin
            case (state_r)
                S_IDLE:    state_s = S_IDLE;
                S_CAPTURE: begin
                    if (load) begin
                        state_s = S_CAPTURE;
                    end else if (cap_count_s != {(AW+1){1'b0}}) begin
                        state_s = S_HOLD;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (step_pulse && (idx_ext_s < count)) begin
                        state_s = S_F0;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_F0:      state_s = S_F1;
                S_F1:      state_s = S_F2;
                S_F2:      state_s = S_F3;
                S_F3:      state_s = S_EVAL;
                S_EVAL:    state_s = S_WRITE;
                S_WRITE: begin
                    if (last_s) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_HOLD;
                    end
                end
                S_DONE:    state_s = S_DONE;
                default:   state_s = S_IDLE;
            endcase
        end
    end

    // Registered strobes and status flags, decoded from the upcoming state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            win_valid <= 1'b0;
            res_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we    <= cap_accept_s;
            win_valid <= (state_s == S_EVAL);
            res_we    <= (state_s == S_WRITE);
            busy      <= (state_s inside {S_F0, S_F1, S_F2, S_F3, S_EVAL, S_WRITE});
            done      <= (state_s == S_DONE);
        end
    end

    // Sample capture: write port, fill count and full flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_waddr <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            count     <= {(AW+1){1'b0}};
            full      <= 1'b0;
        end else begin
            if (cap_accept_s) begin
                mem_waddr <= count[AW-1:0];
                mem_wdata <= sample_in;
            end
            if (abort_s) begin
                count <= {(AW+1){1'b0}};
                full  <= 1'b0;
            end else if (cap_accept_s) begin
                count <= cap_count_s;
                full  <= (cap_count_s == DEPTH_C);
            end
        end
    end

    // Window fetch: read address leads the data by one cycle, so each latch trails its read
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_raddr <= {AW{1'b0}};
            win0      <= {DW{1'b0}};
            win1      <= {DW{1'b0}};
            win2      <= {DW{1'b0}};
        end else begin
            case (state_s)
                S_F0:    mem_raddr <= left_s;
                S_F1:    mem_raddr <= idx_r;
                S_F2:    mem_raddr <= right_s;
                default: mem_raddr <= mem_raddr;
            endcase
            case (state_r)
                S_F1:    win0 <= mem_rdata;
                S_F2:    win1 <= mem_rdata;
                S_F3:    win2 <= mem_rdata;
                default: win0 <= win0;
            endcase
        end
    end

    // Result write-back and window index advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_r    <= {AW{1'b0}};
            res_addr <= {AW{1'b0}};
            res_data <= {DW{1'b0}};
            disp_idx <= {AW{1'b0}};
        end else begin
            if (state_r == S_EVAL) begin
                res_data <= med_in;
                res_addr <= idx_r;
            end
            if (abort_s) begin
                idx_r <= {AW{1'b0}};
            end else if (state_r == S_WRITE) begin
                idx_r    <= idx_r + ONE_A;
                disp_idx <= idx_r;
            end
        end
    end

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Scoreboard bench for median_seq_ctrl: a list-based reference model predicts RAM
// writes, windows and results; a negedge monitor pops and compares them.
module tb_median_seq_ctrl;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clock      = 1'b0;
    logic          reset      = 1'b1;
    logic          load       = 1'b0;
    logic          load_pulse = 1'b0;
    logic          step_pulse = 1'b0;
    logic [DW-1:0] sample_in  = 8'd0;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata  = 8'd0;
    logic [DW-1:0] win0, win1, win2;
    logic          win_valid;
    logic [DW-1:0] med_in;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic [DW-1:0] res_data;
    logic [AW:0]   count;
    logic          full, busy, done;
    logic [AW-1:0] disp_idx;

    median_seq_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .load(load), .load_pulse(load_pulse),
        .step_pulse(step_pulse), .sample_in(sample_in),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .win0(win0), .win1(win1), .win2(win2), .win_valid(win_valid), .med_in(med_in),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
        .count(count), .full(full), .busy(busy), .done(done), .disp_idx(disp_idx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Environment: synchronous sample RAM and a min/max median network
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clock) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    function automatic logic [DW-1:0] med_net(input logic [DW-1:0] a, b, c);
        logic [DW-1:0] lo, hi;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        return (c < lo) ? lo : ((c > hi) ? hi : c);
    endfunction
    assign med_in = med_net(win0, win1, win2);

    typedef struct { int addr; int data; }        wr_t;
    typedef struct { int l; int c; int r; }       win_t;
    typedef struct { int addr; int data; int cy; } res_t;
    wr_t  exp_mem[$];
    win_t exp_win[$];
    res_t exp_res[$];

    int samples[$];
    int m_idx = 0, last_acc = -100, m_last_addr = 0, mem_seen = 0;
    bit m_cap = 0, m_hold = 0, m_done = 0;
    int checks = 0, errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the next prediction in its queue
    wr_t  m_e;
    win_t w_e;
    res_t r_e;
    always @(negedge clock) begin
        if (mem_we) begin
            mem_seen++;
            if (exp_mem.size() == 0) begin
                checks++; errors++;
                $display("FAIL mem_we: unexpected write addr %0d data %0d, none required", mem_waddr, mem_wdata);
            end else begin
                m_e = exp_mem.pop_front();
                check("mem_waddr", mem_waddr, m_e.addr);
                check("mem_wdata", mem_wdata, m_e.data);
            end
        end
        if (win_valid) begin
            if (exp_win.size() == 0) begin
                checks++; errors++;
                $display("FAIL win_valid: unexpected window %0d,%0d,%0d", win0, win1, win2);
            end else begin
                w_e = exp_win.pop_front();
                check("win0", win0, w_e.l);
                check("win1", win1, w_e.c);
                check("win2", win2, w_e.r);
            end
        end
        if (res_we) begin
            if (exp_res.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_we: unexpected write addr %0d data %0d", res_addr, res_data);
            end else begin
                r_e = exp_res.pop_front();
                check("res_addr", res_addr, r_e.addr);
                check("res_data", res_data, r_e.data);
                check("res_cycle", cyc, r_e.cy);
            end
        end
    end

    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic model_clear();
        samples.delete(); m_idx = 0; m_done = 0; last_acc = -100;
        exp_win.delete(); exp_res.delete();
    endtask

    task automatic set_load(input bit v);
        load = v;
        if (v) begin
            model_clear(); m_cap = 1; m_hold = 0;
        end else begin
            m_cap = 0; m_hold = (samples.size() > 0);
        end
        tick();
    endtask

    task automatic pulse_load(input int d, input bit fall);
        sample_in  = DW'(d);
        load_pulse = 1'b1;
        if (m_cap && samples.size() < DEPTH) begin
            exp_mem.push_back('{samples.size(), d});
            samples.push_back(d);
        end
        if (fall) begin
            load = 1'b0; m_cap = 0; m_hold = (samples.size() > 0);
        end
        tick();
        load_pulse = 1'b0;
    endtask

    task automatic load_list(input int vals[$]);
        set_load(1'b1);
        foreach (vals[i]) pulse_load(vals[i], 1'b0);
        set_load(1'b0);
        ticks(2);
    endtask

    // Reference: window from the stored list with edge replication, median by sorting
    task automatic step();
        int n, l, c, r, med;
        int q[$];
        step_pulse = 1'b1;
        n = samples.size();
        if (m_hold && !m_done && m_idx < n && (cyc - last_acc) >= 7) begin
            c = samples[m_idx];
            l = (m_idx == 0)     ? c : samples[m_idx-1];
            r = (m_idx == n - 1) ? c : samples[m_idx+1];
            q = '{l, c, r};
            q.sort();
            med = q[1];
            exp_win.push_back('{l, c, r});
            exp_res.push_back('{m_idx, med, cyc + 6});
            m_last_addr = m_idx;
            m_idx++;
            if (m_idx == n) m_done = 1;
            last_acc = cyc;
        end
        tick();
        step_pulse = 1'b0;
    endtask

    task automatic check_status(input string tag);
        ticks(12);
        check({tag, "_mem_pending"}, exp_mem.size(), 0);
        check({tag, "_win_pending"}, exp_win.size(), 0);
        check({tag, "_res_pending"}, exp_res.size(), 0);
        check({tag, "_count"}, count, samples.size());
        check({tag, "_full"}, full, samples.size() == DEPTH);
        check({tag, "_done"}, done, m_done);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_disp_idx"}, disp_idx, m_last_addr);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_strobes"}, {mem_we, win_valid, res_we}, 0);
        check({tag, "_flags"}, {full, busy, done}, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_win"}, {win0, win1, win2}, 0);
        check({tag, "_res"}, {res_addr, res_data}, 0);
        check({tag, "_addrs"}, {mem_waddr, mem_raddr, disp_idx, mem_wdata}, 0);
    endtask

    initial begin
        int vals[$];
        int n;
        #1 reset = 1'b0;
        #2 check_zero("reset");
        ticks(2);
        @(negedge clock) reset = 1'b1;
        tick();

        // Directed five-sample run, last sample entered in the same cycle load falls
        set_load(1'b1);
        pulse_load(10, 1'b0); pulse_load(200, 1'b0); pulse_load(30, 1'b0); pulse_load(40, 1'b0);
        pulse_load(250, 1'b1);
        ticks(2);
        repeat (6) begin step(); ticks(7); end
        check_status("five");

        // Single sample replicates into all three window slots
        load_list('{77});
        step(); ticks(10); step();
        check_status("single");

        // Overfill: the 65th pulse must be ignored
        set_load(1'b1);
        mem_seen = 0;
        repeat (65) pulse_load($urandom_range(0, 255), 1'b0);
        set_load(1'b0);
        ticks(2);
        check("fill_writes", mem_seen, 64);
        check("fill_count", count, 64);
        check("fill_full", full, 1);
        while (!m_done) begin step(); ticks(7); end
        check_status("fill");

        // Step while busy is dropped; the step at cycle 7 is the next accepted one
        load_list('{5, 9, 1});
        step(); ticks(2); step(); ticks(3); step(); ticks(7); step();
        check_status("spacing");

        // Load raised during F2 aborts the fetch
        load_list('{100, 20, 60, 80});
        step(); ticks(2);
        set_load(1'b1);
        check("abort_count", count, 0);
        check("abort_busy", busy, 0);
        pulse_load(3, 1'b0); pulse_load(1, 1'b0); pulse_load(2, 1'b0);
        set_load(1'b0);
        ticks(2);
        repeat (3) begin step(); ticks(7); end
        check_status("abort");

        // Reset during EVAL clears everything; afterwards the block idles
        load_list('{11, 22, 33});
        step(); ticks(4);
        reset = 1'b0;
        #1 check_zero("midrst");
        model_clear(); exp_mem.delete(); m_cap = 0; m_hold = 0; m_last_addr = 0;
        ticks(2);
        @(negedge clock) reset = 1'b1;
        tick();
        pulse_load(55, 1'b0);
        ticks(2);
        step(); ticks(2); step();
        check_status("postrst");

        // Randomised rounds with random step spacing
        repeat (3) begin
            n = $urandom_range(1, 12);
            vals.delete();
            repeat (n) vals.push_back($urandom_range(0, 255));
            load_list(vals);
            for (int k = 0; k < 60 && !m_done; k++) begin
                step();
                ticks($urandom_range(2, 9));
            end
            check_status("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
